fp_mul: RTL and testbench
=========================

// Module: fp_mul
// PURPOSE
//  Pipelined IEEE-754 binary32 multiplier; the producer side of the PE datapath. Its product
//  (PE_mult) feeds fp_add as an addend inside each systolic PE. Single clock, fixed latency,
//  valid-tagged, stallable via en. Round-to-nearest-even, flush-to-zero, canonical NaN.
// PARAMETERS
//  QNAN   32'h7FC0_0000  canonical NaN emitted for any NaN result
//  LAT    4              pipeline depth in enabled cycles; localparam, not overridable
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  en         in   1   pipeline advance; 0 = every stage register holds
//  in_valid   in   1   PE_a/PE_b carry an operand pair this cycle (sampled only when en=1)
//  PE_a       in   32  binary32 operand A
//  PE_b       in   32  binary32 operand B
//  out_valid  out  1   PE_mult holds a finished product
//  PE_mult    out  32  binary32 product A*B
// BEHAVIOUR
//  - Reset: at a clk edge with rst=1, all stage valids clear; out_valid=0; PE_mult=32'h0.
//    rst has priority over en. Pairs in flight are discarded, never emitted.
//  - Latency: a pair accepted at edge N (en=1, in_valid=1) appears with out_valid=1 after edge
//    N+3 (4 registered stages); each en=0 cycle adds one. en=0 freezes out_valid and PE_mult.
//  - Bubbles: in_valid=0 with en=1 inserts a bubble; out_valid=0 for that slot; PE_mult holds
//    its last value.
//  - S1 unpack/classify: sign, exp, frac; class ZERO (exp==0, subnormals flushed), INF
//    (exp==FF, frac==0), NAN (exp==FF, frac!=0), NORM (hidden 1 prepended -> 24-bit mant).
//  - S2 multiply: sign_r = sa^sb; exp_sum = ea+eb-127 in 10-bit signed; P = ma*mb, 48 bits,
//    P in [2^46, 2^48).
//  - S3 normalize+round: if P[47], mant=P[47:24], guard=P[23], sticky=|P[22:0], exp_sum+1;
//    else mant=P[46:23], guard=P[22], sticky=|P[21:0]. Round up iff guard & (sticky | mant[0]).
//  - S4 post-round/pack: a round carry out of 24 bits shifts right 1, exp+1.
//      exp>=255 -> {sign_r, 8'hFF, 23'h0} (signed inf)
//      exp<=0   -> {sign_r, 31'h0} (FTZ signed zero)
//      else     -> {sign_r, exp[7:0], mant[22:0]}
//  - Special priority (decided in S1, carried down the pipe, overrides S4 arithmetic):
//    any NAN -> QNAN; INF*ZERO -> QNAN; INF*any other -> signed inf; ZERO*finite -> signed zero.
//  - No inexact/overflow flags. Sign of zero and inf results is always sa^sb.
// STRUCTURE
//  - Shared package fp32_pkg: typedef struct packed {sign; exp[7:0]; frac[22:0]} fp32_t;
//    enum fp_class_e {FP_ZERO, FP_NORM, FP_INF, FP_NAN}; constants FP32_BIAS=127,
//    FP32_QNAN, FP32_PINF. fp_add adopts the same package.
//  - One sub-module: fp32_unpack (combinational: fp32_t -> sign, exp, 24-bit mant, class),
//    instantiated twice in S1.
//  - Remainder: one always_ff per stage; the 24x24 product is a single `*` (synth infers DSP).
// TESTING
//  - 0x40000000 * 0x40400000 (2*3) -> 0x40C00000 exactly 4 enabled cycles later; out_valid 1 cycle.
//  - 0x3FC00000^2 (1.5^2) -> 0x40100000; 0xBF800000*0x40000000 -> 0xC0000000; back-to-back every cycle, all in order.
//  - Rounding: 0x3F800001^2 -> 0x3F800002; 0x7F000000*0x40000000 -> 0x7F800000; 0x0D800000^2 -> 0x00000000.
//  - Specials: 0x7F800000*0x00000000 -> 0x7FC00000; 0xFF800000*0x40000000 -> 0xFF800000;
//    0x7FC00001*0x3F800000 -> 0x7FC00000; 0x80000000*0x40000000 -> 0x80000000.
//  - Stall: 3 pairs in flight, en=0 for 5 cycles -> outputs frozen; resume -> same 3 results, no loss or duplication.
//  - Reset mid-op: rst=1 for 1 cycle with 3 pairs in flight -> out_valid=0, PE_mult=0 next cycle; none emitted afterwards.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 types and constants for the PE datapath.
// Used by fp_mul and fp_add.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int          FP32_BIAS = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  typedef struct packed {
    logic        valid;
    logic        sign;
    logic        special;
    logic [31:0] spec_val;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
  } mul_s1_t;

  typedef struct packed {
    logic               valid;
    logic               sign;
    logic               special;
    logic [31:0]        spec_val;
    logic signed [9:0]  exp_sum;
    logic [47:0]        prod;
  } mul_s2_t;

  typedef struct packed {
    logic               valid;
    logic               sign;
    logic               special;
    logic [31:0]        spec_val;
    logic signed [9:0]  exp;
    logic [24:0]        mant;
  } mul_s3_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into sign, exponent, mantissa and class.
// Subnormals classify as zero (flush-to-zero).
module fp32_unpack
  import fp32_pkg::*;
(
  input  fp32_t       x,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant,
  output fp_class_e   cls
);

  always_comb begin
    sign = x.sign;
    exp  = x.exp;
    mant = {1'b1, x.frac};
    cls  = FP_NORM;
    unique case (1'b1)
      (x.exp == 8'h00): begin
        cls  = FP_ZERO;
        mant = 24'h0;
      end
      (x.exp == 8'hFF && x.frac == 23'h0):
        cls = FP_INF;
      (x.exp == 8'hFF && x.frac != 23'h0):
        cls = FP_NAN;
      default:
        cls = FP_NORM;
    endcase
  end

endmodule

// File: rtl/fp_mul.sv
// Four-stage binary32 multiplier: unpack, multiply, round, pack.
// RNE rounding, flush-to-zero, canonical NaN; en stalls all stages.
module fp_mul
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] PE_a,
  input  logic [31:0] PE_b,
  output logic        out_valid,
  output logic [31:0] PE_mult
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  fp_class_e   ca, cb;

  fp32_unpack u_unpack_a (
    .x    (fp32_t'(PE_a)),
    .sign (sa),
    .exp  (ea),
    .mant (ma),
    .cls  (ca)
  );

  fp32_unpack u_unpack_b (
    .x    (fp32_t'(PE_b)),
    .sign (sb),
    .exp  (eb),
    .mant (mb),
    .cls  (cb)
  );

  logic        sign_in;
  logic        spec;
  logic [31:0] sval;

  // Special results are fixed here and bypass the arithmetic below.
  always_comb begin
    sign_in = sa ^ sb;
    spec    = 1'b1;
    sval    = FP32_QNAN;
    if (ca == FP_NAN || cb == FP_NAN) begin
      sval = FP32_QNAN;
    end else if ((ca == FP_INF && cb == FP_ZERO) ||
                 (cb == FP_INF && ca == FP_ZERO)) begin
      sval = FP32_QNAN;
    end else if (ca == FP_INF || cb == FP_INF) begin
      sval = {sign_in, FP32_PINF[30:0]};
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      sval = {sign_in, 31'h0};
    end else begin
      spec = 1'b0;
      sval = 32'h0;
    end
  end

  mul_s1_t s1;
  mul_s2_t s2;
  mul_s3_t s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else if (en) begin
      s1.valid    <= in_valid;
      s1.sign     <= sign_in;
      s1.special  <= spec;
      s1.spec_val <= sval;
      s1.ea       <= ea;
      s1.eb       <= eb;
      s1.ma       <= ma;
      s1.mb       <= mb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else if (en) begin
      s2.valid    <= s1.valid;
      s2.sign     <= s1.sign;
      s2.special  <= s1.special;
      s2.spec_val <= s1.spec_val;
      s2.exp_sum  <= 10'({2'b00, s1.ea})
                   + 10'({2'b00, s1.eb})
                   - 10'(FP32_BIAS);
      s2.prod     <= 48'(s1.ma) * 48'(s1.mb);
    end
  end

  logic [23:0]       nmant;
  logic              guard, sticky, rnd_up;
  logic signed [9:0] nexp;

  always_comb begin
    if (s2.prod[47]) begin
      nmant  = s2.prod[47:24];
      guard  = s2.prod[23];
      sticky = |s2.prod[22:0];
      nexp   = s2.exp_sum + 10'sd1;
    end else begin
      nmant  = s2.prod[46:23];
      guard  = s2.prod[22];
      sticky = |s2.prod[21:0];
      nexp   = s2.exp_sum;
    end
    rnd_up = guard & (sticky | nmant[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3 <= '0;
    end else if (en) begin
      s3.valid    <= s2.valid;
      s3.sign     <= s2.sign;
      s3.special  <= s2.special;
      s3.spec_val <= s2.spec_val;
      s3.exp      <= nexp;
      s3.mant     <= {1'b0, nmant} + 25'(rnd_up);
    end
  end

  logic [22:0]       pfrac;
  logic signed [9:0] pexp;
  logic [31:0]       result;

  // A round carry can only produce 2^24, so the shifted fraction is 0.
  always_comb begin
    if (s3.mant[24]) begin
      pfrac = s3.mant[23:1];
      pexp  = s3.exp + 10'sd1;
    end else begin
      pfrac = s3.mant[22:0];
      pexp  = s3.exp;
    end
    if (s3.special) begin
      result = s3.spec_val;
    end else if (pexp >= 10'sd255) begin
      result = {s3.sign, FP32_PINF[30:0]};
    end else if (pexp <= 10'sd0) begin
      result = {s3.sign, 31'h0};
    end else begin
      result = {s3.sign, pexp[7:0], pfrac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      PE_mult   <= 32'h0;
    end else if (en) begin
      out_valid <= s3.valid;
      if (s3.valid) begin
        PE_mult <= result;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul.sv
// Randomized bench for fp_mul against an arithmetic reference model.
// Directed vectors cover latency, rounding, specials, stall and reset.
module tb_fp_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [31:0] PE_a;
  logic [31:0] PE_b;
  logic        out_valid;
  logic [31:0] PE_mult;

  int errs   = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  int nout   = 0;
  bit last_en = 1'b0;

  always #5 clk = ~clk;

  fp_mul dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .PE_a      (PE_a),
    .PE_b      (PE_b),
    .out_valid (out_valid),
    .PE_mult   (PE_mult)
  );

  function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned fa, fb, p, m, rem, half;
    bit na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = 64'(a[22:0]);
    fb = 64'(b[22:0]);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb) return 32'h7FC00000;
    if ((ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    p  = ((64'd1 << 23) | fa) * ((64'd1 << 23) | fb);
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  // Timing model: four slots advancing on each enabled edge.
  bit          mv [4];
  logic [31:0] mr [4];
  bit          exp_v = 1'b0;
  logic [31:0] exp_r = 32'h0;

  always @(posedge clk) begin
    last_en <= en && !rst;
    if (rst) begin
      for (int i = 0; i < 4; i++) mv[i] <= 1'b0;
      exp_v <= 1'b0;
      exp_r <= 32'h0;
    end else if (en) begin
      for (int i = 1; i < 4; i++) begin
        mv[i] <= mv[i-1];
        mr[i] <= mr[i-1];
      end
      mv[0] <= in_valid;
      mr[0] <= in_valid ? ref_mul(PE_a, PE_b) : 32'h0;
      exp_v <= mv[2];
      if (mv[2]) exp_r <= mr[2];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks += 2;
      if (out_valid !== exp_v) begin
        errs++;
        $display("FAIL out_valid t=%0t got=%b exp=%b",
                 $time, out_valid, exp_v);
      end
      if (PE_mult !== exp_r) begin
        errs++;
        $display("FAIL PE_mult t=%0t got=%h exp=%h",
                 $time, PE_mult, exp_r);
      end
      if (last_en && out_valid) nout++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  task automatic drive(input bit e, input bit v,
                       input logic [31:0] a, input logic [31:0] b);
    en       = e;
    in_valid = v;
    PE_a     = a;
    PE_b     = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: r[30:0] = 31'h0;
      1: r[30:0] = {8'hFF, 23'h0};
      2: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      3: r[30:23] = 8'h00;
      4: r[30:23] = 8'($urandom_range(190, 254));
      5: r[30:23] = 8'($urandom_range(1, 64));
      6: r[22:0] = 23'h7FFFFF;
      default: if (r[30:23] == 8'hFF) r[30] = 1'b0;
    endcase
    return r;
  endfunction

  localparam int NV = 11;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [31:0] vr [NV];

  initial begin
    int cnt;
    va = '{32'h40000000, 32'h3FC00000, 32'hBF800000, 32'h3F800001,
           32'h7F000000, 32'h0D800000, 32'h7F800000, 32'hFF800000,
           32'h7FC00001, 32'h80000000, 32'h3F800000};
    vb = '{32'h40400000, 32'h3FC00000, 32'h40000000, 32'h3F800001,
           32'h40000000, 32'h0D800000, 32'h00000000, 32'h40000000,
           32'h3F800000, 32'h40000000, 32'h00400000};
    vr = '{32'h40C00000, 32'h40100000, 32'hC0000000, 32'h3F800002,
           32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
           32'h7FC00000, 32'h80000000, 32'h00000000};

    for (int i = 0; i < NV; i++)
      chk($sformatf("model_vec%0d", i), ref_mul(va[i], vb[i]), vr[i]);

    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    PE_a = 32'h0;
    PE_b = 32'h0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    drive(1, 0, 0, 0);
    rst = 1'b0;
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_mult", PE_mult, 32'h0);

    drive(1, 1, 32'h40000000, 32'h40400000);
    cnt = 1;
    while (!out_valid && cnt < 12) begin
      drive(1, 0, 0, 0);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'd4);
    chk("lat_value", PE_mult, 32'h40C00000);
    drive(1, 0, 0, 0);
    chk("lat_single", {31'h0, out_valid}, 32'h0);
    chk("bubble_hold", PE_mult, 32'h40C00000);

    nout = 0;
    for (int i = 0; i < NV; i++) drive(1, 1, va[i], vb[i]);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0);
    chk("b2b_count", 32'(nout), 32'(NV));

    nout = 0;
    for (int i = 0; i < 3; i++) drive(1, 1, va[i+1], vb[i+1]);
    for (int i = 0; i < 5; i++) drive(0, 1, $urandom, $urandom);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0);
    chk("stall_count", 32'(nout), 32'd3);
    chk("stall_last", PE_mult, 32'h3F800002);

    for (int i = 0; i < 3; i++) drive(1, 1, va[i], vb[i]);
    rst = 1'b1;
    drive(1, 0, 0, 0);
    rst = 1'b0;
    chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_mult", PE_mult, 32'h0);
    nout = 0;
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0);
    chk("rst_no_emit", 32'(nout), 32'd0);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            rnd_op(), rnd_op());
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
